// File: rtl/sm83_fetch.sv
// SM83 instruction fetch unit: reads opcode bytes one at a time, presents
// them to the decoder, handles the 0xCB prefix and assembles 8/16-bit
// immediates. Supports redirect (branch/interrupt) and halt/wake.
module sm83_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  o_instr,
    output logic        o_is_instr16,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    input  logic [1:0]  i_imm_cnt,
    output logic [15:0] o_imm16,
    output logic        o_imm_valid,
    output logic [15:0] o_pc,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    input  logic        i_halt,
    input  logic        i_wake
);

    typedef enum logic [2:0] {
        FETCH_OP,
        PRESENT,
        FETCH_IMM_LO,
        FETCH_IMM_HI,
        HALTED
    } state_t;

    state_t      r_state, w_state_nx;
    logic [15:0] r_pc, w_pc_nx;
    logic        r_req, w_req_nx;
    logic [7:0]  r_instr, w_instr_nx;
    logic        r_is16, w_is16_nx;
    logic [15:0] r_opc, w_opc_nx;
    logic [15:0] r_imm16, w_imm16_nx;
    logic        r_imm_vld, w_imm_vld_nx;
    logic [7:0]  r_lo, w_lo_nx;
    logic        r_two, w_two_nx;
    logic        r_cb, w_cb_nx;
    logic        r_halt_pend, w_halt_pend_nx;
    logic        w_ack;

    // An ack only counts while our own request is up.
    assign w_ack = mem_ack & r_req;

    assign mem_req       = r_req;
    assign mem_addr      = r_pc;
    assign o_instr       = r_instr;
    assign o_is_instr16  = r_is16;
    assign o_instr_valid = (r_state == PRESENT);
    assign o_imm16       = r_imm16;
    assign o_imm_valid   = r_imm_vld;
    assign o_pc          = r_opc;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= FETCH_OP;
            r_pc        <= RESET_PC;
            r_req       <= 1'b0;
            r_instr     <= 8'h00;
            r_is16      <= 1'b0;
            r_opc       <= RESET_PC;
            r_imm16     <= 16'h0000;
            r_imm_vld   <= 1'b0;
            r_lo        <= 8'h00;
            r_two       <= 1'b0;
            r_cb        <= 1'b0;
            r_halt_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pc        <= w_pc_nx;
            r_req       <= w_req_nx;
            r_instr     <= w_instr_nx;
            r_is16      <= w_is16_nx;
            r_opc       <= w_opc_nx;
            r_imm16     <= w_imm16_nx;
            r_imm_vld   <= w_imm_vld_nx;
            r_lo        <= w_lo_nx;
            r_two       <= w_two_nx;
            r_cb        <= w_cb_nx;
            r_halt_pend <= w_halt_pend_nx;
        end
    end

    // Next-state and next-value logic; redirect overrides everything.
    always_comb begin
        w_state_nx     = r_state;
        w_pc_nx        = r_pc;
        w_instr_nx     = r_instr;
        w_is16_nx      = r_is16;
        w_opc_nx       = r_opc;
        w_imm16_nx     = r_imm16;
        w_imm_vld_nx   = 1'b0;
        w_lo_nx        = r_lo;
        w_two_nx       = r_two;
        w_cb_nx        = r_cb;
        w_halt_pend_nx = r_halt_pend;

        if (i_redirect) begin
            w_state_nx     = FETCH_OP;
            w_pc_nx        = i_redirect_pc;
            w_cb_nx        = 1'b0;
            w_halt_pend_nx = 1'b0;
        end else begin
            case (r_state)
                FETCH_OP: begin
                    if (w_ack) begin
                        if (i_halt || r_halt_pend) begin
                            // Halt requested mid-access: drop the byte, keep PC.
                            w_state_nx     = HALTED;
                            w_halt_pend_nx = 1'b0;
                        end else begin
                            w_instr_nx = mem_rdata;
                            w_is16_nx  = r_cb;
                            w_opc_nx   = r_pc;
                            w_pc_nx    = r_pc + 16'd1;
                            w_state_nx = PRESENT;
                        end
                    end else if (i_halt) begin
                        if (r_req) w_halt_pend_nx = 1'b1;
                        else       w_state_nx     = HALTED;
                    end
                end
                PRESENT: begin
                    if (i_instr_ready) begin
                        if (r_is16)                w_cb_nx = 1'b0;
                        else if (r_instr == 8'hCB) w_cb_nx = 1'b1;
                    end
                    if (i_halt) begin
                        // An unaccepted byte is rewound so wake re-presents it.
                        w_state_nx = HALTED;
                        if (!i_instr_ready) w_pc_nx = r_opc;
                    end else if (i_instr_ready) begin
                        if (!r_is16 && r_instr != 8'hCB && i_imm_cnt != 2'd0) begin
                            w_state_nx = FETCH_IMM_LO;
                            w_two_nx   = i_imm_cnt[1];
                        end else begin
                            w_state_nx = FETCH_OP;
                        end
                    end
                end
                FETCH_IMM_LO: begin
                    if (i_halt) begin
                        w_state_nx = HALTED;
                    end else if (w_ack) begin
                        w_lo_nx = mem_rdata;
                        w_pc_nx = r_pc + 16'd1;
                        if (r_two) begin
                            w_state_nx = FETCH_IMM_HI;
                        end else begin
                            w_imm16_nx   = {8'h00, mem_rdata};
                            w_imm_vld_nx = 1'b1;
                            w_state_nx   = FETCH_OP;
                        end
                    end
                end
                FETCH_IMM_HI: begin
                    if (i_halt) begin
                        w_state_nx = HALTED;
                    end else if (w_ack) begin
                        w_imm16_nx   = {mem_rdata, r_lo};
                        w_imm_vld_nx = 1'b1;
                        w_pc_nx      = r_pc + 16'd1;
                        w_state_nx   = FETCH_OP;
                    end
                end
                HALTED: begin
                    if (i_wake && !i_halt) w_state_nx = FETCH_OP;
                end
                default: w_state_nx = FETCH_OP;
            endcase
        end

        // Request is up in every fetch state except the cycle right after an
        // ack or a redirect, which gives the one-cycle drop between accesses.
        w_req_nx = !i_redirect && !w_ack &&
                   (w_state_nx == FETCH_OP || w_state_nx == FETCH_IMM_LO ||
                    w_state_nx == FETCH_IMM_HI);
    end

endmodule
